sram_access_controller: RTL and testbench

Sequences MEM-stage load/store requests onto the 16-bit external SRAM used as data memory. Each 32-bit word access is split into two 16-bit half-word phases, each with a programmable wait count. While an access is in flight the block deasserts `ready`, and the pipeline uses that as its freeze signal. It sits between the MEM stage and the SRAM pins, alongside the hazard logic that already stalls on `Exe_MEM_R_EN`.

---
 rtl/sram_access_controller_pkg.sv | 12 +
 rtl/sram_access_controller_wait_counter.sv | 32 +++
 rtl/sram_access_controller.sv | 135 +++++++++++++
 tb/tb_sram_access_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_access_controller_pkg.sv
// Shared types and constants for the half-word SRAM access controller.
package sram_access_controller_pkg;
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

   localparam int SRAM_DW = 16;
   localparam int WORD_W  = 32;
   localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;

   function automatic int cnt_width(input int wait_cycles);
      return $clog2(wait_cycles);
   endfunction
endpackage

// File: rtl/sram_access_controller_wait_counter.sv
// Per-phase wait counter: synchronous clear has priority over enable; tc marks the last cycle.
module sram_wait_counter
   import sram_access_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = 3,
   parameter int CW          = cnt_width(WAIT_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_access_controller.sv
// Splits 32-bit MEM-stage loads/stores into two timed 16-bit SRAM phases and
// freezes the pipeline (ready=0) until the access completes.
module sram_access_controller
   import sram_access_controller_pkg::*;
#(
   parameter int          WAIT_CYCLES = 3,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          SRAM_AW     = 18
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic                wr_en,
   input  logic [WORD_W-1:0]   address,
   input  logic [WORD_W-1:0]   write_data,
   output logic [WORD_W-1:0]   read_data,
   output logic                ready,
   output logic [SRAM_AW-1:0]  sram_addr,
   output logic [SRAM_DW-1:0]  sram_dq_out,
   input  logic [SRAM_DW-1:0]  sram_dq_in,
   output logic                sram_dq_oe,
   output logic                sram_we_n
);
   localparam int CW = cnt_width(WAIT_CYCLES);

   state_e               state_q, state_d;
   logic [SRAM_AW-2:0]   idx_q;
   logic [SRAM_DW-1:0]   wdata_hi_q;
   logic [SRAM_DW-1:0]   lo_q;
   logic                 op_we_q;
   logic [WORD_W-1:0]    read_data_q;
   logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
   logic [SRAM_DW-1:0]   sram_dq_out_q, sram_dq_out_d;
   logic                 sram_dq_oe_q, sram_dq_oe_d;
   logic                 sram_we_n_q, sram_we_n_d;
   logic                 latch_req;
   logic                 tc;
   logic [WORD_W-1:0]    offset;
   logic [SRAM_AW-2:0]   req_idx;
   logic                 unused_offset_bits;

   // Out-of-window addresses simply wrap and alias onto the SRAM.
   assign offset             = address - 32'(BASE_ADDR);
   assign req_idx            = offset[SRAM_AW:2];
   assign unused_offset_bits = ^{offset[WORD_W-1:SRAM_AW+1], offset[1:0]};

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES),
      .CW         (CW)
   ) u_wait_counter (
      .clk_i(clk),
      .rst_i(rst),
      .clr_i((state_q == IDLE) || tc),
      .en_i ((state_q == LOW) || (state_q == HIGH)),
      .tc_o (tc)
   );

   // Pin values are computed for the cycle being entered so every pin is a flop.
   always_comb begin
      state_d       = state_q;
      latch_req     = 1'b0;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = 1'b0;
      sram_we_n_d   = 1'b1;
      case (state_q)
         IDLE: begin
            if (wr_en || rd_en) begin
               state_d       = LOW;
               latch_req     = 1'b1;
               sram_addr_d   = {req_idx, 1'b0};
               sram_dq_out_d = write_data[SRAM_DW-1:0];
               sram_dq_oe_d  = wr_en;
            end
         end
         LOW: begin
            sram_dq_oe_d = op_we_q;
            if (tc) begin
               state_d       = HIGH;
               sram_addr_d   = {idx_q, 1'b1};
               sram_dq_out_d = wdata_hi_q;
            end else begin
               sram_we_n_d = ~op_we_q;
            end
         end
         HIGH: begin
            if (tc) begin
               state_d = DONE;
            end else begin
               sram_dq_oe_d = op_we_q;
               sram_we_n_d  = ~op_we_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
         read_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
         if ((state_q == HIGH) && tc && !op_we_q)
            read_data_q <= {sram_dq_in, lo_q};
      end
   end

   // Request latches and the low read half need no reset.
   always_ff @(posedge clk) begin
      if (latch_req) begin
         idx_q      <= req_idx;
         wdata_hi_q <= write_data[WORD_W-1:SRAM_DW];
         op_we_q    <= wr_en;
      end
      if ((state_q == LOW) && tc && !op_we_q)
         lo_q <= sram_dq_in;
   end

   assign ready       = (state_q == IDLE) ? ~(rd_en | wr_en) : (state_q == DONE);
   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = sram_dq_out_q;
   assign sram_dq_oe  = sram_dq_oe_q;
   assign sram_we_n   = sram_we_n_q;
endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller with a small behavioural SRAM.
module tb_sram_access_controller;
   localparam int W = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;

   logic [15:0] mem [0:15];
   int checks = 0;
   int errors = 0;

   sram_access_controller #(
      .WAIT_CYCLES(W),
      .BASE_ADDR  (1024),
      .SRAM_AW    (18)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in (sram_dq_in),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!sram_we_n)
         mem[sram_addr[3:0]] <= sram_dq_out;
   end
   assign sram_dq_in = mem[sram_addr[3:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with no request
      tick();
      tick();
      check("rst_ready", ready, 1);
      check("rst_we_n", sram_we_n, 1);
      check("rst_oe", sram_dq_oe, 0);
      check("rst_read_data", read_data, 0);
      check("rst_addr", sram_addr, 0);
      rst = 1'b0;
      tick();

      // Store 0xDEADBEEF at 1028 -> half-words 2 (BEEF) and 3 (DEAD)
      wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
      #1;
      check("st_req_ready", ready, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("st_ready_c%0d", c), ready, (c == 7));
         if (c < 7) begin
            check($sformatf("st_oe_c%0d", c), sram_dq_oe, 1);
            check($sformatf("st_we_n_c%0d", c), sram_we_n, (c == 1 || c == 4));
            check($sformatf("st_addr_c%0d", c), sram_addr, (c <= 3) ? 2 : 3);
            check($sformatf("st_dq_c%0d", c), sram_dq_out, (c <= 3) ? 32'hBEEF : 32'hDEAD);
         end else begin
            check("st_done_oe", sram_dq_oe, 0);
            check("st_done_we_n", sram_we_n, 1);
         end
      end
      wr_en = 1'b0;
      tick();
      check("st_idle_ready", ready, 1);
      check("st_mem_lo", mem[2], 32'hBEEF);
      check("st_mem_hi", mem[3], 32'hDEAD);

      // Load back from 1028
      rd_en = 1'b1; address = 32'd1028;
      #1;
      check("ld_req_ready", ready, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("ld_ready_c%0d", c), ready, (c == 7));
         check($sformatf("ld_we_n_c%0d", c), sram_we_n, 1);
         check($sformatf("ld_oe_c%0d", c), sram_dq_oe, 0);
         if (c == 1) check("ld_addr_lo", sram_addr, 2);
         if (c == 4) check("ld_addr_hi", sram_addr, 3);
      end
      check("ld_data", read_data, 32'hDEADBEEF);
      rd_en = 1'b0;
      tick();
      check("ld_data_held", read_data, 32'hDEADBEEF);
      check("ld_idle_ready", ready, 1);

      // Back-to-back: store at 1032 held through DONE, then load from 1032
      wr_en = 1'b1; address = 32'd1032; write_data = 32'h12345678;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("bb_st_ready_c%0d", c), ready, (c == 7));
      end
      tick();
      check("bb_no_reaccept_oe", sram_dq_oe, 0);
      check("bb_idle_ready", ready, 0);
      wr_en = 1'b0; rd_en = 1'b1;
      #1;
      check("bb_ld_req_ready", ready, 0);
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("bb_ld_ready_c%0d", c), ready, (c == 7));
         if (c == 1) check("bb_ld_addr", sram_addr, 4);
         if (c == 1) check("bb_ld_oe", sram_dq_oe, 0);
      end
      check("bb_ld_data", read_data, 32'h12345678);
      rd_en = 1'b0;
      check("bb_mem_lo", mem[4], 32'h5678);
      check("bb_mem_hi", mem[5], 32'h1234);
      tick();

      // Simultaneous rd_en and wr_en: write wins
      rd_en = 1'b1; wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("sim_ready_c%0d", c), ready, (c == 7));
         if (c == 1) begin
            check("sim_oe", sram_dq_oe, 1);
            check("sim_addr", sram_addr, 6);
            check("sim_dq", sram_dq_out, 32'hF00D);
         end
      end
      check("sim_read_data_kept", read_data, 32'h12345678);
      rd_en = 1'b0; wr_en = 1'b0;
      tick();
      check("sim_mem_lo", mem[6], 32'hF00D);
      check("sim_mem_hi", mem[7], 32'hCAFE);

      // Reset in cycle 4 of a store at 1040
      wr_en = 1'b1; address = 32'd1040; write_data = 32'h55AA33CC;
      for (int c = 1; c <= 4; c++) tick();
      check("mr_pre_addr", sram_addr, 9);
      check("mr_pre_oe", sram_dq_oe, 1);
      rst = 1'b1; wr_en = 1'b0;
      #1;
      check("mr_ready", ready, 1);
      check("mr_we_n", sram_we_n, 1);
      check("mr_oe", sram_dq_oe, 0);
      check("mr_addr", sram_addr, 0);
      check("mr_dq_out", sram_dq_out, 0);
      check("mr_read_data", read_data, 0);
      check("mr_mem_lo", mem[8], 32'h33CC);
      tick();
      rst = 1'b0;
      tick();
      rd_en = 1'b1; address = 32'd1028;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("mr_ld_ready_c%0d", c), ready, (c == 7));
      end
      check("mr_ld_data", read_data, 32'hDEADBEEF);
      rd_en = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
